// File: rtl/int_pend.sv
// int_pend: synchronises external interrupt lines, applies level/edge trigger
// and holds pend requests for the CLIC; overflow CSR enabled by INT_PEND_OVF_EN.
module int_pend #(
    parameter int unsigned NumSrc     = 16,
    parameter int unsigned SyncStages = 2,
    parameter logic [11:0] ModeAddr   = 12'h7C0,
    parameter logic [11:0] OvfAddr    = 12'h7C1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NumSrc-1:0] ext_irq,
    input  logic              csr_enable,
    input  logic [11:0]       csr_addr,
    input  logic [2:0]        csr_op,
    input  logic [4:0]        rs1_zimm,
    input  logic [31:0]       rs1_data,
    input  logic [NumSrc-1:0] pend_ack,
    output logic [NumSrc-1:0] pend_req,
    output logic [31:0]       csr_out
);

    logic [SyncStages-1:0][NumSrc-1:0] sync_q, sync_d;
    logic [NumSrc-1:0] hist_q, hist_d;
    logic [NumSrc-1:0] pend_q, pend_d;
    logic [NumSrc-1:0] mode_q, mode_d;
    logic [NumSrc-1:0] sync_s, ev, ovf;
    logic [NumSrc-1:0] opnd;
    logic [31:0]       operand;
    logic              mode_wr, ovf_wr;
    logic              unused_bits;

    assign sync_s  = sync_q[SyncStages-1];
    // edge sources need the history low; level sources fire on s alone
    assign ev      = sync_s & ~(hist_q & mode_q);
    assign operand = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;
    assign opnd    = operand[NumSrc-1:0];
    assign mode_wr = csr_enable && (csr_addr == ModeAddr)
                     && (csr_op[1:0] != 2'b00);
    assign ovf_wr  = csr_enable && (csr_addr == OvfAddr)
                     && (csr_op[1:0] != 2'b00);
    assign unused_bits = ^operand[31:NumSrc];
    assign pend_req = pend_q;

    always_comb begin
        sync_d = {sync_q[SyncStages-2:0], ext_irq};
        hist_d = sync_s;
        pend_d = ev | (pend_q & ~pend_ack);
        mode_d = mode_q;
        if (mode_wr) begin
            case (csr_op[1:0])
                2'b01:   mode_d = opnd;
                2'b10:   mode_d = mode_q | opnd;
                2'b11:   mode_d = mode_q & ~opnd;
                default: mode_d = mode_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= '0;
            pend_q <= '0;
            mode_q <= '0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            pend_q <= pend_d;
            mode_q <= mode_d;
        end
    end

`ifdef INT_PEND_OVF_EN
    logic [NumSrc-1:0] ovf_q, ovf_d;

    // a set in the same cycle as a clear wins
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_wr) ovf_d = ovf_q & ~opnd;
        ovf_d = ovf_d | (ev & mode_q & pend_q & ~pend_ack);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_q <= '0;
        else       ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_wr;
    assign ovf = '0;
`endif

    always_comb begin
        csr_out = '0;
        if (csr_addr == ModeAddr)     csr_out = 32'(mode_q);
        else if (csr_addr == OvfAddr) csr_out = 32'(ovf);
    end

endmodule

// File: doc/int_pend.md
# int_pend

External interrupt front end feeding the n-CLIC pend bits. Synchronises up to `NumSrc` asynchronous interrupt lines and applies per-source level/edge trigger selection. Holds each resulting event as a pend request until the CLIC acknowledges that it has written the corresponding entry pend bit. Owns two CSRs: trigger mode and overflow status.

## Interface
- `NumSrc`, default `VecSize`: number of interrupt sources, 1..16; source k maps to CLIC entry k.
- `SyncStages`, default 2: synchroniser depth, at least 2.
- `ModeAddr`, default `IntModeAddr`: CSR address of the trigger-mode register.
- `OvfAddr`, default `IntOvfAddr`: CSR address of the overflow register.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  reset, asynchronous and active-high.
- `ext_irq`  in  NumSrc  raw external interrupt lines; asynchronous, active-high.
- `csr_enable`  in  1  CSR access strobe.
- `csr_addr`  in  `CsrAddrT`  CSR address.
- `csr_op`  in  `csr_op_t`  CSR operation (RW/RS/RC and their immediate forms).
- `rs1_zimm`  in  `r`  immediate operand, used by immediate ops.
- `rs1_data`  in  `word`  register operand, used by register ops.
- `pend_ack`  in  NumSrc  CLIC has written pend=1 into entry k this cycle.
- `pend_req`  out  NumSrc  registered request to set pend in entry k.
- `csr_out`  out  `word`  read data; 0 when `csr_addr` matches neither register.

## Operation
- Per source: a `SyncStages` flop chain produces `s[k]`; a history flop `h[k]` holds the previous `s[k]`.
- Trigger mode `mode[k]`: 0 = level, 1 = rising edge.
- Event definition:
  - Edge mode: `ev[k] = s[k] & ~h[k]`.
  - Level mode: `ev[k] = s[k]`.
- Request flop update, per source:
  - If `ev` is set, `pend_req` is set next cycle.
  - Else if `pend_ack` is set, `pend_req` is cleared next cycle.
  - Otherwise `pend_req` holds.
  - Event takes precedence over ack, so no event is lost on a simultaneous event and ack.
- Level mode: `pend_req` stays asserted while the line stays high, even across acks. After the line drops, the first ack clears the request.
- `pend_ack` while `pend_req=0` is ignored.
- Mode CSR at `ModeAddr`:
  - bits [NumSrc-1:0] = `mode`; upper bits read 0 and ignore writes.
  - RW/RS/RC semantics per `csr_op`; immediate forms use the zero-extended `rs1_zimm`.
  - Write commits at the clock edge when `csr_enable` is high and the address matches.
  - A mode change never clears an existing `pend_req`.
- Overflow CSR at `OvfAddr`: see Configuration.
- `csr_out` is combinational from `csr_addr` and returns the current register value (pre-write) for any matching address, independent of `csr_enable`.

## Timing
- Reset values: sync chain, `h`, `pend_req`, `mode` and overflow bits are all 0; `csr_out` is 0 for non-matching addresses.
- Latency, with `SyncStages=2`: `ext_irq[k]` rises before edge E0, giving `s=1` after E1 and `pend_req=1` after E2. In general the latency is `SyncStages+1` edges.
- Edge mode: `ev` is high for exactly one cycle per rising edge of `s`.
- A line held high through reset release counts as a rising edge, because `h` resets to 0.
- Ack in cycle C with no event in C: `pend_req` reads 0 from C+1.
- Edge mode, back-to-back: a second rising edge of `s` arriving while `pend_req=1` and un-acked merges into the pending request.
- Reset asserted mid-operation clears all state immediately; pending requests are discarded.

## Configuration
- Macro `INT_PEND_OVF_EN`.
- Defined:
  - Overflow bit `ovf[k]` sets when `ev[k]` occurs in edge mode while `pend_req[k]=1` and `pend_ack[k]=0`.
  - `ovf` is readable at `OvfAddr` bits [NumSrc-1:0].
  - Writes are write-1-to-clear, using the `rs1_data`/`zimm` operand for all op types.
  - If a set condition and a clear occur in the same cycle, the bit stays set.
- Undefined: no overflow flops exist; `OvfAddr` reads 0, writes are ignored, and merged events are lost silently.

## Test plan
- Edge, single: `mode=1`, `ext_irq[3]` pulses high 5 cycles → `pend_req[3]` rises 3 edges after input; `pend_ack[3]` → `pend_req[3]` clears next cycle; no re-assert.
- Level, held: `mode=0`, `ext_irq[1]` high 20 cycles, ack every 4 cycles → `pend_req[1]` stays 1 throughout; drop line, then ack → clears.
- Simultaneous: edge event and `pend_ack` in same cycle on source 0 → `pend_req[0]` stays 1; `ovf[0]` stays 0.
- Overflow, with `INT_PEND_OVF_EN`: two edges on source 2 without ack → `OvfAddr` reads 0x4; write 0x4 (RW) → reads 0x0. Without the macro → reads 0x0.
- CSR ops: CSRRW `ModeAddr` 0xF0, then CSRRS zimm 0x01, then CSRRC 0x10 → reads 0xE1; upper bits remain 0.
- Reset mid-request: `pend_req=0x0A`, assert `reset` asynchronously between edges → `pend_req=0`, `mode=0` immediately. A line held high across release → request appears 3 edges after the first post-reset edge.
